fifo_uart_tx: RTL and testbench

FIFO-draining UART transmitter: the consumer side of the push/pop FIFO. Whenever enabled and the FIFO is non-empty, it pops one word and sends it on a single serial line as `bitWidth/8` consecutive 8N1 UART frames, least-significant byte first. It sits between the FIFO's pop port and the board's TX pin, and gives the processor a fire-and-forget serial output path.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_baud_counter.sv | 25 ++
 rtl/fifo_uart_tx.sv | 105 ++++++++++
 tb/tb_fifo_uart_tx.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame geometry.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;  // start + 8 data + stop

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..clocksPerBit-1 and pulses tick on the last cycle.
module uart_baud_counter #(
  parameter int clocksPerBit = 434
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int               CW   = $clog2(clocksPerBit);
  localparam logic [CW-1:0]    LAST = CW'(clocksPerBit - 1);

  logic [CW-1:0] r_count;

  assign tick = (r_count == LAST);

  // Free-running count within a bit period; restarts on clear or after the last cycle.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset || clear || tick) r_count <= '0;
    else                        r_count <= r_count + CW'(1);
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: pops one word when idle and enabled, then
// sends it LSB byte first as consecutive 8N1 frames on txd.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int bitWidth     = 32,
  parameter int clocksPerBit = 434
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                fifoEmpty,
  input  logic [bitWidth-1:0] fifoPopData,
  output logic                fifoPop,
  output logic                txd,
  output logic                busy
);

  localparam int              NBYTES    = bitWidth / UART_DATA_BITS;
  localparam int              BYW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BYW-1:0]  LAST_BYTE = BYW'(NBYTES - 1);
  localparam logic [2:0]      LAST_BIT  = 3'(UART_DATA_BITS - 1);

  uart_state_e         r_state, w_next_state;
  logic [BYW-1:0]      r_byte;
  logic [2:0]          r_bit;
  logic [bitWidth-1:0] r_shift;
  logic                r_txd, r_busy;
  logic                w_tick, w_clear, w_pop, w_txd_next;
  logic [2:0]          w_bit_idx;

  // Bit timer restarts on every state entry and is held cleared while idle.
  assign w_clear = (r_state == IDLE) || (w_next_state != r_state);

  uart_baud_counter #(.clocksPerBit(clocksPerBit)) u_baud (
    .clock (clock),
    .reset (reset),
    .clear (w_clear),
    .tick  (w_tick)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic: each non-idle state lasts whole bit periods.
  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    w_next_state = r_state;
    case (r_state)
      IDLE:  if (w_pop)                        w_next_state = START;
      START: if (w_tick)                       w_next_state = DATA;
      DATA:  if (w_tick && r_bit == LAST_BIT)  w_next_state = STOP;
      STOP:  if (w_tick)                       w_next_state = (r_byte < LAST_BYTE) ? START : IDLE;
      default:                                 w_next_state = IDLE;
    endcase
  end

  // Output decode: pop strobe, plus the line level for the upcoming cycle.
  always_comb begin
    w_pop     = (r_state == IDLE) && enable && !fifoEmpty && !reset;
    w_bit_idx = 3'd0;
    if (r_state == DATA) w_bit_idx = w_tick ? r_bit + 3'd1 : r_bit;
    case (w_next_state)
      START:   w_txd_next = 1'b0;
      DATA:    w_txd_next = r_shift[w_bit_idx];
      default: w_txd_next = 1'b1;
    endcase
  end

  // Datapath: word capture, byte/bit counters and registered line outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_shift <= '0;
      r_byte  <= '0;
      r_bit   <= '0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_txd  <= w_txd_next;
      r_busy <= (w_next_state != IDLE);
      case (r_state)
        IDLE: if (w_pop) begin
          r_shift <= fifoPopData;
          r_byte  <= '0;
          r_bit   <= '0;
        end
        START: if (w_tick) r_bit <= '0;
        DATA:  if (w_tick) r_bit <= r_bit + 3'd1;
        STOP:  if (w_tick && r_byte < LAST_BYTE) begin
          r_byte  <= r_byte + BYW'(1);
          r_shift <= r_shift >> UART_DATA_BITS;
        end
        default: ;
      endcase
    end
  end

  assign fifoPop = w_pop;
  assign txd     = r_txd;
  assign busy    = r_busy;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench: the bench acts as the FIFO and predicts the serial
// waveform from the frame rules (start, 8 data LSB first, stop per byte).
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int BW  = 32;
  localparam int NB  = BW / 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          fifoEmpty = 1'b1;
  logic [BW-1:0] fifoPopData = '0;
  logic          fifoPop, txd, busy;

  always #5 clock = ~clock;

  fifo_uart_tx #(.bitWidth(BW), .clocksPerBit(CPB)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .fifoEmpty   (fifoEmpty),
    .fifoPopData (fifoPopData),
    .fifoPop     (fifoPop),
    .txd         (txd),
    .busy        (busy)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] fifo_q[$];   // bench-side FIFO contents
  logic        exp_q[$];    // predicted txd levels of the word in flight
  int          pop_cyc[$];  // cycles in which the DUT popped
  int          busy_run = 0;
  bit          aborted = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Expected line levels for one word: per byte, start bit, data LSB first, stop bit.
  task automatic add_word(input logic [31:0] w);
    for (int b = 0; b < NB; b++) begin
      for (int k = 0; k < CPB; k++) exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++)
        for (int k = 0; k < CPB; k++) exp_q.push_back(w[8*b+i]);
      for (int k = 0; k < CPB; k++) exp_q.push_back(1'b1);
    end
  endtask

  task automatic drive_fifo();
    fifoEmpty   = (fifo_q.size() == 0);
    fifoPopData = fifoEmpty ? BW'($urandom) : fifo_q[0];
  endtask

  // One clock cycle: compare outputs mid-cycle, then let the FIFO react to a pop.
  task automatic step();
    logic exp_pop, dut_pop;
    @(negedge clock);
    exp_pop = (exp_q.size() == 0) && enable && (fifo_q.size() != 0) && !reset;
    check("pop",  fifoPop, exp_pop);
    check("txd",  txd,  (exp_q.size() != 0) ? exp_q[0] : 1'b1);
    check("busy", busy, exp_q.size() != 0);
    if (busy === 1'b1) begin
      busy_run++;
      if (reset) aborted = 1;
    end else if (busy_run > 0) begin
      if (!aborted) check("busy_len", busy_run, NB * 10 * CPB);
      busy_run = 0;
      aborted  = 0;
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    if (reset) exp_q.delete();
    if (exp_pop) add_word(fifo_q[0]);
    dut_pop = fifoPop;
    if (dut_pop === 1'b1) pop_cyc.push_back(cyc);
    @(posedge clock);
    #1;
    if (dut_pop === 1'b1 && fifo_q.size() != 0) void'(fifo_q.pop_front());
    drive_fifo();
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset held with a word available: no pop, idle line.
    enable = 1'b1;
    fifo_q.push_back(32'h4433_2211);
    drive_fifo();
    @(posedge clock);
    #1;
    run(3);
    check("reset_pops", pop_cyc.size(), 0);

    // Single word; first pop lands on the first cycle after reset falls.
    reset = 1'b0;
    run(200);
    check("single_pops", pop_cyc.size(), 1);
    check("single_pop_cyc", pop_cyc[0], 3);

    // Back-to-back words: second pop 161 cycles after the first.
    pop_cyc.delete();
    fifo_q.push_back(32'h0000_00FF);
    fifo_q.push_back(32'hA5A5_A5A5);
    drive_fifo();
    run(340);
    check("b2b_pops", pop_cyc.size(), 2);
    if (pop_cyc.size() == 2) check("b2b_gap", pop_cyc[1] - pop_cyc[0], NB * 10 * CPB + 1);

    // Enable drop mid-word: word completes, nothing more until enable returns.
    pop_cyc.delete();
    fifo_q.push_back(32'h1234_5678);
    fifo_q.push_back(32'h9ABC_DEF0);
    drive_fifo();
    run(20);
    enable = 1'b0;
    run(250);
    check("en_drop_pops", pop_cyc.size(), 1);
    check("en_drop_left", fifo_q.size(), 1);
    enable = 1'b1;
    run(170);
    check("en_back_pops", pop_cyc.size(), 2);

    // Reset during DATA of the second byte: aborted word is not re-sent.
    pop_cyc.delete();
    fifo_q.push_back(32'hDEAD_BEEF);
    fifo_q.push_back(32'hCAFE_F00D);
    fifo_q.push_back(32'h0102_0304);
    drive_fifo();
    run(51);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    run(340);
    check("rst_mid_pops", pop_cyc.size(), 3);
    check("rst_mid_left", fifo_q.size(), 0);

    // Empty FIFO: line stays idle.
    pop_cyc.delete();
    run(200);
    check("empty_pops", pop_cyc.size(), 0);

    // Randomised traffic with enable toggles and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0 && fifo_q.size() < 4) begin
        fifo_q.push_back($urandom);
        drive_fifo();
      end
      if ($urandom_range(99) == 0) enable = ~enable;
      reset = ($urandom_range(499) == 0);
      step();
    end
    reset  = 1'b0;
    enable = 1'b1;
    run(700);
    check("drain_left", fifo_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
